// File: rtl/ctl_pkg.sv
// Shared constants and types for the EBOX CTL sequencer: SPEC codes, FSM states and
// AR half-select encodings.
package ctl_pkg;

  localparam logic [3:0] SPEC_ARL_SEL  = 4'h1;
  localparam logic [3:0] SPEC_ARR_SEL  = 4'h2;
  localparam logic [3:0] SPEC_XCRY_AR0 = 4'h5;

  // Bit 0 selects ARL, bit 1 selects ARR.
  localparam logic [1:0] HALF_NONE = 2'b00;
  localparam logic [1:0] HALF_ARL  = 2'b01;
  localparam logic [1:0] HALF_ARR  = 2'b10;
  localparam logic [1:0] HALF_BOTH = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StPiSave,
    StLongHi,
    StLongLo
  } ctl_state_e;

endpackage

// File: rtl/ctl_seg_decode.sv
// Expands a 2-bit AR half code into a per-segment mask; segment 0 is the MSB of ARL.
module ctl_seg_decode
  import ctl_pkg::*;
#(
  parameter int unsigned NSEG = 4
) (
  input  logic [1:0]      half,
  output logic [0:NSEG-1] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < NSEG; i++) begin
      mask[i] = (i < NSEG / 2) ? half[0] : half[1];
    end
  end

endmodule

// File: rtl/ctl_seq.sv
// EBOX CTL sequencer: registered AR strobes, ADX carry-in and the PI flag-save sequence.
// Define CTL_LONG_EN to build the ADlong double-word sequence (LONG_HI/LONG_LO).
module ctl_seq
  import ctl_pkg::*;
#(
  parameter int unsigned WORD_W         = 36,
  parameter int unsigned NSEG           = 4,
  parameter int unsigned PI_SAVE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CRAM_valid,
  output logic              CTL_ready,
  input  logic [1:0]        CRAM_ARload,
  input  logic [1:0]        CRAM_ARclr,
  input  logic [3:0]        CRAM_SPEC,
  input  logic              CRAM_ADcarry,
  input  logic              CRAM_ADlong,
  input  logic [0:WORD_W-1] EDP_AR,
  input  logic              PCplus1inh,
  output logic              CTL_ARL_SEL,
  output logic              CTL_ARR_SEL,
  output logic [0:NSEG-1]   CTL_ARload,
  output logic [0:NSEG-1]   CTL_ARclr,
  output logic              ADXcarry36,
  output logic              ADlong,
  output logic              PIcycleSaveFlags
);

  localparam int unsigned CntW = $clog2(PI_SAVE_CYCLES + 1);

  ctl_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [0:NSEG-1] load_q, load_d, clr_q, clr_d;
  logic arl_sel_q, arl_sel_d, arr_sel_q, arr_sel_d;
  logic carry_q, carry_d, adlong_q, adlong_d, flags_q, flags_d;

  logic [0:NSEG-1] ld_mask, clr_mask, arl_mask;
  logic accept, spec_xcry, go_pi, go_long;
  logic unused_in;

  ctl_seg_decode #(.NSEG(NSEG)) u_load_dec (
    .half (CRAM_ARload),
    .mask (ld_mask)
  );

  ctl_seg_decode #(.NSEG(NSEG)) u_clr_dec (
    .half (CRAM_ARclr),
    .mask (clr_mask)
  );

  always_comb begin
    arl_mask = '0;
    for (int i = 0; i < NSEG / 2; i++) arl_mask[i] = 1'b1;
  end

  assign CTL_ready = (state_q == StIdle);
  assign accept    = CRAM_valid & CTL_ready;
  assign spec_xcry = (CRAM_SPEC == SPEC_XCRY_AR0);
  assign go_pi     = spec_xcry & PCplus1inh;

`ifdef CTL_LONG_EN
  // PI save takes priority; a coinciding long request is dropped.
  assign go_long   = CRAM_ADlong & ~go_pi;
  assign unused_in = ^EDP_AR[1:WORD_W-1];
`else
  assign go_long   = 1'b0;
  assign unused_in = ^{CRAM_ADlong, EDP_AR[1:WORD_W-1]};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = '0;
    clr_d     = '0;
    arl_sel_d = 1'b0;
    arr_sel_d = 1'b0;
    carry_d   = 1'b0;
    adlong_d  = 1'b0;
    flags_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (go_pi) begin
            state_d   = StPiSave;
            cnt_d     = CntW'(PI_SAVE_CYCLES);
            flags_d   = 1'b1;
            arl_sel_d = 1'b1;
            if (PI_SAVE_CYCLES == 1) load_d = arl_mask;
          end else begin
            load_d    = ld_mask & ~clr_mask;
            clr_d     = clr_mask;
            arl_sel_d = (CRAM_SPEC == SPEC_ARL_SEL);
            arr_sel_d = (CRAM_SPEC == SPEC_ARR_SEL);
            carry_d   = (EDP_AR[0] & spec_xcry) ^ CRAM_ADcarry;
            if (go_long) begin
              state_d  = StLongHi;
              adlong_d = 1'b1;
            end
          end
        end
      end
      StPiSave: begin
        // cnt_q counts the PISAVE cycles still to run, including the current one.
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d     = cnt_q - CntW'(1);
          flags_d   = 1'b1;
          arl_sel_d = 1'b1;
          if (cnt_q == CntW'(2)) load_d = arl_mask;
        end
      end
`ifdef CTL_LONG_EN
      StLongHi: begin
        state_d  = StLongLo;
        adlong_d = 1'b1;
      end
      StLongLo: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      load_q    <= '0;
      clr_q     <= '0;
      arl_sel_q <= 1'b0;
      arr_sel_q <= 1'b0;
      carry_q   <= 1'b0;
      adlong_q  <= 1'b0;
      flags_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      clr_q     <= clr_d;
      arl_sel_q <= arl_sel_d;
      arr_sel_q <= arr_sel_d;
      carry_q   <= carry_d;
      adlong_q  <= adlong_d;
      flags_q   <= flags_d;
    end
  end

  assign CTL_ARload       = load_q;
  assign CTL_ARclr        = clr_q;
  assign CTL_ARL_SEL      = arl_sel_q;
  assign CTL_ARR_SEL      = arr_sel_q;
  assign ADXcarry36       = carry_q;
  assign ADlong           = adlong_q;
  assign PIcycleSaveFlags = flags_q;

endmodule

// File: tb/tb_ctl_seq.sv
// Directed bench for ctl_seq: expected output words are queued as stimulus is driven
// and compared after each rising edge.
module tb_ctl_seq;

  typedef struct packed {
    logic       ready;
    logic [0:3] load;
    logic [0:3] clr;
    logic       arl;
    logic       arr;
    logic       carry;
    logic       adlong;
    logic       flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        CRAM_valid;
  logic        CTL_ready;
  logic [1:0]  CRAM_ARload;
  logic [1:0]  CRAM_ARclr;
  logic [3:0]  CRAM_SPEC;
  logic        CRAM_ADcarry;
  logic        CRAM_ADlong;
  logic [0:35] EDP_AR;
  logic        PCplus1inh;
  logic        CTL_ARL_SEL;
  logic        CTL_ARR_SEL;
  logic [0:3]  CTL_ARload;
  logic [0:3]  CTL_ARclr;
  logic        ADXcarry36;
  logic        ADlong;
  logic        PIcycleSaveFlags;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        exp_q[$];

  ctl_seq #(.WORD_W(36), .NSEG(4), .PI_SAVE_CYCLES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .CRAM_valid       (CRAM_valid),
    .CTL_ready        (CTL_ready),
    .CRAM_ARload      (CRAM_ARload),
    .CRAM_ARclr       (CRAM_ARclr),
    .CRAM_SPEC        (CRAM_SPEC),
    .CRAM_ADcarry     (CRAM_ADcarry),
    .CRAM_ADlong      (CRAM_ADlong),
    .EDP_AR           (EDP_AR),
    .PCplus1inh       (PCplus1inh),
    .CTL_ARL_SEL      (CTL_ARL_SEL),
    .CTL_ARR_SEL      (CTL_ARR_SEL),
    .CTL_ARload       (CTL_ARload),
    .CTL_ARclr        (CTL_ARclr),
    .ADXcarry36       (ADXcarry36),
    .ADlong           (ADlong),
    .PIcycleSaveFlags (PIcycleSaveFlags)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic rdy, input logic [3:0] ld, input logic [3:0] cl,
                              input logic arl, input logic arr, input logic cy,
                              input logic lng, input logic fl);
    exp_t e;
    e.ready = rdy; e.load = ld; e.clr = cl; e.arl = arl; e.arr = arr;
    e.carry = cy; e.adlong = lng; e.flags = fl;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [1:0] ld, input logic [1:0] cl,
                       input logic [3:0] spec, input logic adc, input logic adl,
                       input logic ar0, input logic pci);
    CRAM_valid   = v;
    CRAM_ARload  = ld;
    CRAM_ARclr   = cl;
    CRAM_SPEC    = spec;
    CRAM_ADcarry = adc;
    CRAM_ADlong  = adl;
    EDP_AR       = {ar0, 35'($urandom)};
    PCplus1inh   = pci;
  endtask

  // Queue the expected post-edge outputs, advance one edge, then compare.
  task automatic tick(input string tag, input exp_t e);
    exp_t obs, want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs.ready = CTL_ready;  obs.load = CTL_ARload;  obs.clr = CTL_ARclr;
    obs.arl = CTL_ARL_SEL;  obs.arr = CTL_ARR_SEL;  obs.carry = ADXcarry36;
    obs.adlong = ADlong;    obs.flags = PIcycleSaveFlags;
    want = exp_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed rdy=%b ld=%b clr=%b arl=%b arr=%b cy=%b lng=%b fl=%b expected rdy=%b ld=%b clr=%b arl=%b arr=%b cy=%b lng=%b fl=%b",
             tag, obs.ready, obs.load, obs.clr, obs.arl, obs.arr, obs.carry, obs.adlong,
             obs.flags, want.ready, want.load, want.clr, want.arl, want.arr, want.carry,
             want.adlong, want.flags);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("reset", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    reset = 1'b0;

    drive(1'b1, 2'b11, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("load_both", mk(1, 4'b1111, 4'b0000, 0, 0, 0, 0, 0));
    drive(1'b1, 2'b11, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("clr_wins", mk(1, 4'b0011, 4'b1100, 0, 0, 0, 0, 0));
    drive(1'b1, 2'b00, 2'b00, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("xcry_ar0", mk(1, 4'b0000, 4'b0000, 0, 0, 1, 0, 0));
    drive(1'b1, 2'b00, 2'b00, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("xcry_adc", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    drive(1'b1, 2'b00, 2'b00, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("arl_sel", mk(1, 4'b0000, 4'b0000, 1, 0, 1, 0, 0));
    drive(1'b1, 2'b10, 2'b10, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("arr_sel_clr", mk(1, 4'b0000, 4'b0011, 0, 1, 0, 0, 0));
    drive(1'b0, 2'b11, 2'b11, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("no_accept", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));

    // PI flag-save: request fields are ignored, ARL loads only in the last cycle.
    drive(1'b1, 2'b10, 2'b11, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("pi_cyc1", mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 1));
    tick("pi_cyc2", mk(0, 4'b1100, 4'b0000, 1, 0, 0, 0, 1));
    drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("pi_done", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));

    drive(1'b1, 2'b01, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef CTL_LONG_EN
    tick("long_hi", mk(0, 4'b1100, 4'b0000, 0, 0, 1, 1, 0));
    drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("long_lo", mk(0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0));
    tick("long_done", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
`else
    tick("long_off", mk(1, 4'b1100, 4'b0000, 0, 0, 1, 0, 0));
    drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("long_off_idle", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
`endif

    // PI and long together: PI wins, ADlong never raised.
    drive(1'b1, 2'b11, 2'b00, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1);
    tick("pri_cyc1", mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 1));
    drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("pri_cyc2", mk(0, 4'b1100, 4'b0000, 1, 0, 0, 0, 1));
    tick("pri_done", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));

    // Reset in the first PI cycle: no ARL load afterwards.
    drive(1'b1, 2'b00, 2'b00, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("rst_pi_cyc1", mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 1));
    drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick("rst_pi_reset", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick("rst_pi_after", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
